// File: rtl/yutorina_bus_master_if.sv
// Requesting end of the shared bus: request, wait for grant, strobe until ready, release.
// Optional access timeout enabled by defining BUS_MASTER_TIMEOUT_EN.
module yutorina_bus_master_if #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_as,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              cpu_busy,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    typedef enum logic [1:0] {IDLE, REQ, ACCESS} state_t;

    state_t            state;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wr_data_q;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign cpu_err = 1'b0;
`endif

    assign cpu_busy = (state != IDLE);

    // Bus outputs return to their inactive values whenever the strobe is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rw_q        <= 1'b1;
            addr_q      <= '0;
            wr_data_q   <= '0;
            bus_req_    <= 1'b1;
            bus_as_     <= 1'b1;
            bus_rw      <= 1'b1;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            cpu_rd_data <= '0;
            cpu_done    <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
            cpu_err     <= 1'b0;
            cnt         <= '0;
`endif
        end else begin
            cpu_done <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
            cpu_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (cpu_as) begin
                        rw_q      <= cpu_rw;
                        addr_q    <= cpu_addr;
                        wr_data_q <= cpu_wr_data;
                        bus_req_  <= 1'b0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (!bus_grnt_) begin
                        bus_as_     <= 1'b0;
                        bus_rw      <= rw_q;
                        bus_addr    <= addr_q;
                        bus_wr_data <= wr_data_q;
                        state       <= ACCESS;
`ifdef BUS_MASTER_TIMEOUT_EN
                        cnt         <= '0;
`endif
                    end
                end
                ACCESS: begin
                    // Ready takes priority over an expiry on the same edge.
                    if (!bus_rdy_) begin
                        if (bus_rw) begin
                            cpu_rd_data <= bus_rd_data;
                        end
                        cpu_done    <= 1'b1;
                        bus_req_    <= 1'b1;
                        bus_as_     <= 1'b1;
                        bus_rw      <= 1'b1;
                        bus_addr    <= '0;
                        bus_wr_data <= '0;
                        state       <= IDLE;
                    end
`ifdef BUS_MASTER_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        cpu_err     <= 1'b1;
                        cpu_rd_data <= '0;
                        bus_req_    <= 1'b1;
                        bus_as_     <= 1'b1;
                        bus_rw      <= 1'b1;
                        bus_addr    <= '0;
                        bus_wr_data <= '0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_yutorina_bus_master_if.sv
// Directed self-checking bench for yutorina_bus_master_if (TIMEOUT=4 when BUS_MASTER_TIMEOUT_EN is defined).
module tb_yutorina_bus_master_if;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_as;
    logic        cpu_rw;
    logic [29:0] cpu_addr;
    logic [31:0] cpu_wr_data;
    logic [31:0] cpu_rd_data;
    logic        cpu_done;
    logic        cpu_err;
    logic        cpu_busy;
    logic        bus_req_;
    logic        bus_grnt_;
    logic        bus_as_;
    logic        bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;

    int assert_count = 0;
    int fail_count   = 0;

    yutorina_bus_master_if #(.ADDR_W(30), .DATA_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cpu_as(cpu_as), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
        .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
        .bus_rdy_(bus_rdy_)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic as_v, input logic rw_v, input logic [29:0] addr_v,
                                 input logic [31:0] wdata_v, input logic grnt_v, input logic rdy_v,
                                 input logic [31:0] rdata_v);
        cpu_as      = as_v;
        cpu_rw      = rw_v;
        cpu_addr    = addr_v;
        cpu_wr_data = wdata_v;
        bus_grnt_   = grnt_v;
        bus_rdy_    = rdy_v;
        bus_rd_data = rdata_v;
    endtask

    task automatic checkIdleBus(input string tag);
        checkOutput({tag, "_req"}, 64'(bus_req_), 64'd1);
        checkOutput({tag, "_as"}, 64'(bus_as_), 64'd1);
        checkOutput({tag, "_busy"}, 64'(cpu_busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, '0, '0, 1'b1, 1'b1, '0);
        tick();
        tick();
        // Reset values
        checkIdleBus("rst");
        checkOutput("rst_rw", 64'(bus_rw), 64'd1);
        checkOutput("rst_addr", 64'(bus_addr), 64'd0);
        checkOutput("rst_wdata", 64'(bus_wr_data), 64'd0);
        checkOutput("rst_rdata", 64'(cpu_rd_data), 64'd0);
        checkOutput("rst_done", 64'(cpu_done), 64'd0);
        checkOutput("rst_err", 64'(cpu_err), 64'd0);
        rst = 1'b0;
        tick();

        // Read with immediate grant and ready
        applyStimulus(1'b1, 1'b1, 30'h0000_0100, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        tick();
        checkOutput("rd_req_low", 64'(bus_req_), 64'd0);
        checkOutput("rd_as_high", 64'(bus_as_), 64'd1);
        checkOutput("rd_busy", 64'(cpu_busy), 64'd1);
        cpu_as = 1'b0;
        tick();
        checkOutput("rd_as_low", 64'(bus_as_), 64'd0);
        checkOutput("rd_addr", 64'(bus_addr), 64'h100);
        checkOutput("rd_rw", 64'(bus_rw), 64'd1);
        checkOutput("rd_done_early", 64'(cpu_done), 64'd0);
        tick();
        checkOutput("rd_done", 64'(cpu_done), 64'd1);
        checkOutput("rd_data", 64'(cpu_rd_data), 64'hDEAD_BEEF);
        checkIdleBus("rd_release");
        checkOutput("rd_rel_addr", 64'(bus_addr), 64'd0);
        tick();
        checkOutput("rd_done_pulse", 64'(cpu_done), 64'd0);

        // Write with grant delayed 4 cycles and ready delayed 2 cycles
        applyStimulus(1'b1, 1'b0, 30'h3FFF_FFFF, 32'h1234_5678, 1'b1, 1'b1, 32'hCAFE_0000);
        tick();
        checkOutput("wr_req_low", 64'(bus_req_), 64'd0);
        cpu_as = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("wr_wait_req", 64'(bus_req_), 64'd0);
            checkOutput("wr_wait_as", 64'(bus_as_), 64'd1);
        end
        bus_grnt_ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus_grnt_ = 1'b1;
            checkOutput("wr_as", 64'(bus_as_), 64'd0);
            checkOutput("wr_addr", 64'(bus_addr), 64'h3FFF_FFFF);
            checkOutput("wr_wdata", 64'(bus_wr_data), 64'h1234_5678);
            checkOutput("wr_rw", 64'(bus_rw), 64'd0);
            checkOutput("wr_no_done", 64'(cpu_done), 64'd0);
        end
        bus_rdy_ = 1'b0;
        tick();
        checkOutput("wr_done", 64'(cpu_done), 64'd1);
        checkOutput("wr_rdata_hold", 64'(cpu_rd_data), 64'hDEAD_BEEF);
        checkOutput("wr_rel_rw", 64'(bus_rw), 64'd1);
        checkOutput("wr_rel_wdata", 64'(bus_wr_data), 64'd0);
        checkIdleBus("wr_release");

        // Grant parked on this master while idle
        applyStimulus(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("park_as", 64'(bus_as_), 64'd1);
            checkOutput("park_req", 64'(bus_req_), 64'd1);
        end

        // Request pulsed while busy is ignored
        applyStimulus(1'b1, 1'b1, 30'h0000_0AAA, '0, 1'b0, 1'b1, 32'h5555_AAAA);
        tick();
        cpu_as = 1'b0;
        tick();
        applyStimulus(1'b1, 1'b0, 30'h0000_0BBB, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h5555_AAAA);
        tick();
        checkOutput("busy_addr", 64'(bus_addr), 64'hAAA);
        checkOutput("busy_rw", 64'(bus_rw), 64'd1);
        cpu_as = 1'b0;
        bus_rdy_ = 1'b0;
        tick();
        checkOutput("busy_done", 64'(cpu_done), 64'd1);
        checkOutput("busy_data", 64'(cpu_rd_data), 64'h5555_AAAA);
        tick();
        checkIdleBus("busy_not_taken");

        // Back-to-back reads with the client holding its request
        applyStimulus(1'b1, 1'b1, 30'h0000_0010, '0, 1'b0, 1'b0, 32'h1111_1111);
        tick();
        tick();
        tick();
        checkOutput("b2b_done1", 64'(cpu_done), 64'd1);
        checkOutput("b2b_data1", 64'(cpu_rd_data), 64'h1111_1111);
        checkOutput("b2b_gap_req", 64'(bus_req_), 64'd1);
        applyStimulus(1'b1, 1'b1, 30'h0000_0020, '0, 1'b0, 1'b0, 32'h2222_2222);
        tick();
        checkOutput("b2b_req2", 64'(bus_req_), 64'd0);
        cpu_as = 1'b0;
        tick();
        checkOutput("b2b_addr2", 64'(bus_addr), 64'h20);
        tick();
        checkOutput("b2b_done2", 64'(cpu_done), 64'd1);
        checkOutput("b2b_data2", 64'(cpu_rd_data), 64'h2222_2222);

`ifdef BUS_MASTER_TIMEOUT_EN
        // Timeout with ready never asserted
        applyStimulus(1'b1, 1'b1, 30'h0000_0040, '0, 1'b0, 1'b1, 32'h7777_7777);
        tick();
        cpu_as = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("to_wait_err", 64'(cpu_err), 64'd0);
            checkOutput("to_wait_as", 64'(bus_as_), 64'd0);
        end
        tick();
        checkOutput("to_err", 64'(cpu_err), 64'd1);
        checkOutput("to_no_done", 64'(cpu_done), 64'd0);
        checkOutput("to_rdata", 64'(cpu_rd_data), 64'd0);
        checkIdleBus("to_release");
        tick();
        checkOutput("to_err_pulse", 64'(cpu_err), 64'd0);

        // Ready on the expiry cycle wins
        applyStimulus(1'b1, 1'b1, 30'h0000_0044, '0, 1'b0, 1'b1, 32'h8888_8888);
        tick();
        cpu_as = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        bus_rdy_ = 1'b0;
        tick();
        checkOutput("to_rdy_done", 64'(cpu_done), 64'd1);
        checkOutput("to_rdy_err", 64'(cpu_err), 64'd0);
        checkOutput("to_rdy_data", 64'(cpu_rd_data), 64'h8888_8888);
`endif

        // Reset during ACCESS
        applyStimulus(1'b1, 1'b1, 30'h0000_0080, '0, 1'b0, 1'b1, 32'h9999_9999);
        tick();
        cpu_as = 1'b0;
        tick();
        checkOutput("mid_as_low", 64'(bus_as_), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkIdleBus("mid_rst");
        checkOutput("mid_done", 64'(cpu_done), 64'd0);
        checkOutput("mid_addr", 64'(bus_addr), 64'd0);
        checkOutput("mid_rdata", 64'(cpu_rd_data), 64'd0);
        bus_rdy_ = 1'b0;
        tick();
        checkOutput("mid_after_done", 64'(cpu_done), 64'd0);
        checkIdleBus("mid_after");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
